// File: rtl/alu_sequencer.sv
// Multicycle ALU sequencer: steps one captured request through operand load,
// execute, optional MUL/DIV settle, and LO/HI/destination writeback.
//
// state    | meaning
// IDLE     | ready for a request
// LOAD_Y   | rb onto bus, load Y
// EXEC     | second operand onto bus, ALU runs, Z loads
// WAIT     | MUL/DIV settle, Z keeps loading
// WB_LO    | Z[31:0] to LO (wide) or to ra
// WB_HI    | Z[63:32] to HI (wide only)
// DONE     | completion pulse
module alu_sequencer #(
  parameter int MULDIV_WAIT = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_opcode,
  input  logic [3:0] req_ra,
  input  logic [3:0] req_rb,
  input  logic [3:0] req_rc,
  output logic       gp_out_en,
  output logic [3:0] gp_out_sel,
  output logic       gp_in_en,
  output logic [3:0] gp_in_sel,
  output logic       y_in,
  output logic [4:0] alu_control,
  output logic       z_in,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       lo_in,
  output logic       hi_in,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Y, S_EXEC, S_WAIT, S_WB_LO, S_WB_HI, S_DONE
  } state_t;

  typedef enum logic [1:0] {C_BIN, C_UNARY, C_WIDE, C_ILLEGAL} op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return C_BIN;
      5'b10001, 5'b10010:                     return C_UNARY;
      5'b01111, 5'b10000:                     return C_WIDE;
      default:                                return C_ILLEGAL;
    endcase
  endfunction

  state_t     state_q, state_d;
  op_class_t  cls_q, cls_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [3:0] cnt_q, cnt_d;

  logic       ready_q, ready_d, busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic       out_en_q, out_en_d, in_en_q, in_en_d;
  logic [3:0] out_sel_q, out_sel_d, in_sel_q, in_sel_d;
  logic       y_in_q, y_in_d, z_in_q, z_in_d, zlo_q, zlo_d, zhi_q, zhi_d;
  logic       lo_in_q, lo_in_d, hi_in_q, hi_in_d;
  logic [4:0] alu_q, alu_d;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cls_d = classify(req_opcode);
          op_d  = req_opcode;
          ra_d  = req_ra;
          rb_d  = req_rb;
          rc_d  = req_rc;
          case (classify(req_opcode))
            C_UNARY:   state_d = S_EXEC;
            C_ILLEGAL: state_d = S_DONE;
            default:   state_d = S_LOAD_Y;
          endcase
        end
      end
      S_LOAD_Y: state_d = S_EXEC;
      S_EXEC: begin
        if (cls_q == C_WIDE) begin
          state_d = S_WAIT;
          cnt_d   = 4'(MULDIV_WAIT - 1);
        end else begin
          state_d = S_WB_LO;
        end
      end
      S_WAIT: begin
        // down-counter: terminal count zero ends the settle window
        if (cnt_q == 4'd0) state_d = S_WB_LO;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WB_LO: state_d = (cls_q == C_WIDE) ? S_WB_HI : S_DONE;
      S_WB_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    done_d    = 1'b0;
    illegal_d = 1'b0;
    out_en_d  = 1'b0;
    out_sel_d = 4'd0;
    in_en_d   = 1'b0;
    in_sel_d  = 4'd0;
    y_in_d    = 1'b0;
    z_in_d    = 1'b0;
    zlo_d     = 1'b0;
    zhi_d     = 1'b0;
    lo_in_d   = 1'b0;
    hi_in_d   = 1'b0;
    alu_d     = 5'd0;
    case (state_d)
      S_LOAD_Y: begin
        out_en_d  = 1'b1;
        out_sel_d = rb_d;
        y_in_d    = 1'b1;
      end
      S_EXEC, S_WAIT: begin
        out_en_d  = 1'b1;
        out_sel_d = (cls_d == C_UNARY) ? rb_d : rc_d;
        z_in_d    = 1'b1;
        alu_d     = op_d;
      end
      S_WB_LO: begin
        zlo_d = 1'b1;
        alu_d = op_d;
        if (cls_d == C_WIDE) begin
          lo_in_d = 1'b1;
        end else begin
          in_en_d  = 1'b1;
          in_sel_d = ra_d;
        end
      end
      S_WB_HI: begin
        zhi_d   = 1'b1;
        hi_in_d = 1'b1;
        alu_d   = op_d;
      end
      S_DONE: begin
        done_d    = 1'b1;
        illegal_d = (cls_d == C_ILLEGAL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cls_q     <= C_BIN;
      op_q      <= 5'd0;
      ra_q      <= 4'd0;
      rb_q      <= 4'd0;
      rc_q      <= 4'd0;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      out_en_q  <= 1'b0;
      out_sel_q <= 4'd0;
      in_en_q   <= 1'b0;
      in_sel_q  <= 4'd0;
      y_in_q    <= 1'b0;
      z_in_q    <= 1'b0;
      zlo_q     <= 1'b0;
      zhi_q     <= 1'b0;
      lo_in_q   <= 1'b0;
      hi_in_q   <= 1'b0;
      alu_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      out_en_q  <= out_en_d;
      out_sel_q <= out_sel_d;
      in_en_q   <= in_en_d;
      in_sel_q  <= in_sel_d;
      y_in_q    <= y_in_d;
      z_in_q    <= z_in_d;
      zlo_q     <= zlo_d;
      zhi_q     <= zhi_d;
      lo_in_q   <= lo_in_d;
      hi_in_q   <= hi_in_d;
      alu_q     <= alu_d;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign gp_out_en   = out_en_q;
  assign gp_out_sel  = out_sel_q;
  assign gp_in_en    = in_en_q;
  assign gp_in_sel   = in_sel_q;
  assign y_in        = y_in_q;
  assign z_in        = z_in_q;
  assign zlo_out     = zlo_q;
  assign zhi_out     = zhi_q;
  assign lo_in       = lo_in_q;
  assign hi_in       = hi_in_q;
  assign alu_control = alu_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-cycle output vectors checked against
// hand-derived sequences for each opcode class, abort and held request.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_opcode = 5'd0;
  logic [3:0] req_ra = 4'd0, req_rb = 4'd0, req_rc = 4'd0;
  logic       req_ready, gp_out_en, gp_in_en, y_in, z_in, zlo_out, zhi_out;
  logic       lo_in, hi_in, busy, done, illegal;
  logic [3:0] gp_out_sel, gp_in_sel;
  logic [4:0] alu_control;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.MULDIV_WAIT(2)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc),
    .gp_out_en(gp_out_en), .gp_out_sel(gp_out_sel),
    .gp_in_en(gp_in_en), .gp_in_sel(gp_in_sel),
    .y_in(y_in), .alu_control(alu_control), .z_in(z_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // {ready,busy,done,illegal,oen,osel,ien,isel,y,alu,z,zlo,zhi,lo,hi}
  function automatic logic [24:0] pk(
      input logic rdy, input logic bsy, input logic dn, input logic ill,
      input logic oen, input logic [3:0] osel, input logic ien, input logic [3:0] isel,
      input logic y, input logic [4:0] alu, input logic z, input logic zlo,
      input logic zhi, input logic lo, input logic hi);
    return {rdy, bsy, dn, ill, oen, osel, ien, isel, y, alu, z, zlo, zhi, lo, hi};
  endfunction

  function automatic logic [24:0] obs();
    return {req_ready, busy, done, illegal, gp_out_en, gp_out_sel, gp_in_en, gp_in_sel,
            y_in, alu_control, z_in, zlo_out, zhi_out, lo_in, hi_in};
  endfunction

  localparam logic [24:0] IDLE_V = 25'h1000000;

  // Presents a request for one edge; returns at the negedge of the first cycle after accept.
  task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic hold);
    @(negedge clock);
    req_valid = 1'b1; req_opcode = op; req_ra = ra; req_rb = rb; req_rc = rc;
    @(negedge clock);
    req_valid = hold;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs(), IDLE_V);
    end
  endtask

  task automatic test_add();
    logic [24:0] e [5];
    e[0] = pk(0,1,0,0, 1,4'd1, 0,4'd0, 1,5'd0,  0,0,0,0,0);
    e[1] = pk(0,1,0,0, 1,4'd2, 0,4'd0, 0,5'd3,  1,0,0,0,0);
    e[2] = pk(0,1,0,0, 0,4'd0, 1,4'd3, 0,5'd3,  0,1,0,0,0);
    e[3] = pk(0,1,1,0, 0,4'd0, 0,4'd0, 0,5'd0,  0,0,0,0,0);
    e[4] = IDLE_V;
    issue(5'b00011, 4'd3, 4'd1, 4'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("FAIL add cycle %0d: got %h want %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_not();
    logic [24:0] e [4];
    e[0] = pk(0,1,0,0, 1,4'd7, 0,4'd0, 0,5'b10010, 1,0,0,0,0);
    e[1] = pk(0,1,0,0, 0,4'd0, 1,4'd5, 0,5'b10010, 0,1,0,0,0);
    e[2] = pk(0,1,1,0, 0,4'd0, 0,4'd0, 0,5'd0,     0,0,0,0,0);
    e[3] = IDLE_V;
    issue(5'b10010, 4'd5, 4'd7, 4'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("FAIL not cycle %0d: got %h want %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [24:0] e [8];
    e[0] = pk(0,1,0,0, 1,4'd4, 0,4'd0, 1,5'd0,  0,0,0,0,0);
    e[1] = pk(0,1,0,0, 1,4'd6, 0,4'd0, 0,5'd15, 1,0,0,0,0);
    e[2] = e[1];
    e[3] = e[1];
    e[4] = pk(0,1,0,0, 0,4'd0, 0,4'd0, 0,5'd15, 0,1,0,1,0);
    e[5] = pk(0,1,0,0, 0,4'd0, 0,4'd0, 0,5'd15, 0,0,1,0,1);
    e[6] = pk(0,1,1,0, 0,4'd0, 0,4'd0, 0,5'd0,  0,0,0,0,0);
    e[7] = IDLE_V;
    issue(5'b01111, 4'd9, 4'd4, 4'd6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("FAIL mul cycle %0d: got %h want %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [24:0] e [2];
    e[0] = pk(0,1,1,1, 0,4'd0, 0,4'd0, 0,5'd0, 0,0,0,0,0);
    e[1] = IDLE_V;
    issue(5'b11111, 4'd2, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %h want %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [24:0] wait_v;
    int lohi = 0;
    wait_v = pk(0,1,0,0, 1,4'd3, 0,4'd0, 0,5'b10000, 1,0,0,0,0);
    issue(5'b10000, 4'd1, 4'd2, 4'd3, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (obs() !== wait_v) begin
      errors++;
      $display("FAIL abort wait: got %h want %h", obs(), wait_v);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL abort idle: got %h want %h", obs(), IDLE_V);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (lo_in || hi_in || busy) lohi++;
    end
    checks++;
    if (lohi !== 0) begin
      errors++;
      $display("FAIL abort quiet: got %0d active cycles want 0", lohi);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] e [10];
    int accepts = 0;
    e[0] = pk(0,1,0,0, 1,4'd2, 0,4'd0, 1,5'd0, 0,0,0,0,0);
    e[1] = pk(0,1,0,0, 1,4'd3, 0,4'd0, 0,5'd3, 1,0,0,0,0);
    e[2] = pk(0,1,0,0, 0,4'd0, 1,4'd1, 0,5'd3, 0,1,0,0,0);
    e[3] = pk(0,1,1,0, 0,4'd0, 0,4'd0, 0,5'd0, 0,0,0,0,0);
    e[4] = IDLE_V;
    e[5] = pk(0,1,0,0, 1,4'd5, 0,4'd0, 1,5'd0, 0,0,0,0,0);
    e[6] = pk(0,1,0,0, 1,4'd6, 0,4'd0, 0,5'd4, 1,0,0,0,0);
    e[7] = pk(0,1,0,0, 0,4'd0, 1,4'd4, 0,5'd4, 0,1,0,0,0);
    e[8] = pk(0,1,1,0, 0,4'd0, 0,4'd0, 0,5'd0, 0,0,0,0,0);
    e[9] = IDLE_V;
    issue(5'b00011, 4'd1, 4'd2, 4'd3, 1'b1);
    req_opcode = 5'b00100; req_ra = 4'd4; req_rb = 4'd5; req_rc = 4'd6;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 5) req_valid = 1'b0;
      if (req_valid && req_ready) accepts++;
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("FAIL held cycle %0d: got %h want %h", i + 1, obs(), e[i]);
      end
    end
    checks++;
    if (accepts !== 1) begin
      errors++;
      $display("FAIL held accepts: got %0d want 1", accepts);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_not();
    test_mul();
    test_illegal();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multicycle controller that runs one ALU operation per request. It drives the operand-bus register selects, the Y and Z register load strobes, the ALU control code, and the LO/HI/destination writebacks. It sits between the instruction control unit and the datapath (ALU, Y, Z, LO, HI, general-purpose register file). It owns the ALU for the whole duration of an operation and accepts a new request only when idle.

## Interface
Parameters:
- MULDIV_WAIT, 2: extra settle cycles (1–15) held after EXEC for MUL/DIV before Z is written back.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clear  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a posedge.
- req_opcode  in  5  ALU operation code.
- req_ra  in  4  destination register index.
- req_rb  in  4  first source register index (the Y operand; the b operand for unary ops).
- req_rc  in  4  second source register index (the b operand; the shift/rotate count).
- gp_out_en  out  1  drive register gp_out_sel onto the bus.
- gp_out_sel  out  4  register index driven onto the bus.
- gp_in_en  out  1  load register gp_in_sel from the bus.
- gp_in_sel  out  4  register index loaded from the bus.
- y_in  out  1  load Y from the bus.
- alu_control  out  5  operation code presented to the ALU.
- z_in  out  1  load Z (64-bit) from the ALU result.
- zlo_out  out  1  drive Z[31:0] onto the bus.
- zhi_out  out  1  drive Z[63:32] onto the bus.
- lo_in  out  1  load LO from the bus.
- hi_in  out  1  load HI from the bus.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for an unknown opcode.

## Operation
- Request fields are captured into internal registers on acceptance. Inputs are ignored while busy.
- Opcode classes:
  - Binary: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011.
  - Unary: NEG 10001, NOT 10010.
  - Wide: MUL 01111, DIV 10000.
  - Any other code is illegal.
- States: IDLE, LOAD_Y, EXEC, WAIT, WB_LO, WB_HI, DONE.
- Transitions:
  - IDLE → LOAD_Y on accepting a binary or wide opcode.
  - IDLE → EXEC on accepting a unary opcode.
  - IDLE → DONE on accepting an illegal opcode; illegal is set and no datapath strobes are issued.
  - LOAD_Y → EXEC.
  - EXEC → WAIT for wide opcodes; EXEC → WB_LO otherwise.
  - WAIT stays MULDIV_WAIT cycles (counter), then → WB_LO.
  - WB_LO → WB_HI for wide opcodes; WB_LO → DONE otherwise.
  - WB_HI → DONE.
  - DONE → IDLE.
- Outputs are a Moore decode of state plus the captured request:
  - LOAD_Y: gp_out_en=1, gp_out_sel=rb, y_in=1.
  - EXEC: gp_out_en=1, gp_out_sel=rc (rb for unary), z_in=1.
  - WAIT: same as EXEC, with z_in held high.
  - WB_LO: zlo_out=1. For wide opcodes lo_in=1; otherwise gp_in_en=1 and gp_in_sel=ra.
  - WB_HI: zhi_out=1, hi_in=1.
  - DONE: done=1.
- alu_control equals the captured opcode in every state from EXEC through WB_HI, and 5'b00000 otherwise.
- Wide opcodes never write a general-purpose register. Non-wide opcodes never touch LO or HI.
- All *_sel outputs are 0 when their enable is 0.

## Timing
- Reset:
  - clear forces state to IDLE at the next posedge and has priority over acceptance.
  - After reset: req_ready=1; busy, done, illegal, all strobes, all selects and alu_control are 0.
  - clear mid-operation aborts with no further strobes; a partially completed writeback is not repeated.
- The ALU updates its result on the negedge. Z captures on the posedge that ends EXEC (or the last WAIT cycle), so the ALU has half a cycle to settle for single-cycle ops and MULDIV_WAIT extra full cycles for wide ops.
- Latency, counted from the accept edge to the done-high cycle:
  - binary: 4 cycles (LOAD_Y, EXEC, WB_LO, DONE).
  - unary: 3 cycles.
  - wide: 5+MULDIV_WAIT cycles.
  - illegal: 1 cycle.
- Back-to-back: req_ready rises in the cycle after DONE, so the minimum spacing between binary acceptances is 5 cycles.
- req_valid held high while busy does not queue a request; it is accepted at the first IDLE edge.

## Test plan
- Reset and ADD: assert clear for 2 cycles, then check every output at its reset value. Request ADD ra=3, rb=1, rc=2 → LOAD_Y sel=1 y_in, EXEC sel=2 z_in alu_control=00011, WB_LO gp_in_sel=3, done in cycle 4.
- NOT: request NOT ra=5, rb=7 → no y_in; EXEC gp_out_sel=7; WB_LO writes r5; done in cycle 3.
- MUL with MULDIV_WAIT=2: request MUL rb=4, rc=6 → z_in high for 3 cycles, lo_in then hi_in, gp_in_en never asserted, done in cycle 7.
- Illegal opcode 5'b11111: done and illegal both pulse 1 cycle after accept; y_in, z_in, gp_in_en, lo_in and hi_in stay 0 throughout.
- Abort: clear asserted during WAIT of a DIV → IDLE next cycle, lo_in and hi_in never asserted, req_ready=1.
- Held request: req_valid held high with SUB during a busy ADD → SUB is accepted exactly once, on the edge after ADD's DONE, and alu_control=00100 in its EXEC.
